// File: rtl/mips_pkg.sv
// Shared MIPS multicycle control definitions.
// Opcodes, datapath select encodings and control states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD,
    MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    BEQEX, ADDIEX, ADDIWB, JEX
  } ctrl_state_t;

  // Leaving this state completes an instruction.
  function automatic logic retires(
    ctrl_state_t s,
    logic        mr
  );
    unique case (s)
      MEMWB, RTYPEWB, BEQEX,
      ADDIWB, JEX: retires = 1'b1;
      MEMWR:       retires = mr;
      default:     retires = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Control output decode for the multicycle controller.
// Pure function of current state and memory ready.
module mc_outdec
  import mips_pkg::*;
(
  input  ctrl_state_t state_i,
  input  logic        mem_ready_i,
  output logic        iord_o,
  output logic        memwrite_o,
  output logic        irwrite_o,
  output logic        pcwrite_o,
  output logic        branch_o,
  output logic [1:0]  pcsrc_o,
  output logic        alusrca_o,
  output logic [1:0]  alusrcb_o,
  output logic [1:0]  aluop_o,
  output logic        regdst_o,
  output logic        memtoreg_o,
  output logic        regwrite_o
);

  // Per-state datapath controls; everything idles at 0.
  always_comb begin
    iord_o     = 1'b0;
    memwrite_o = 1'b0;
    irwrite_o  = 1'b0;
    pcwrite_o  = 1'b0;
    branch_o   = 1'b0;
    pcsrc_o    = PC_ALURES;
    alusrca_o  = 1'b0;
    alusrcb_o  = SRCB_B;
    aluop_o    = ALU_ADD;
    regdst_o   = 1'b0;
    memtoreg_o = 1'b0;
    regwrite_o = 1'b0;
    unique case (state_i)
      FETCH: begin
        alusrcb_o = SRCB_FOUR;
        irwrite_o = mem_ready_i;
        pcwrite_o = mem_ready_i;
      end
      DECODE: alusrcb_o = SRCB_IMMSH;
      MEMADR, ADDIEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
      end
      MEMRD: iord_o = 1'b1;
      MEMWB: begin
        memtoreg_o = 1'b1;
        regwrite_o = 1'b1;
      end
      MEMWR: begin
        iord_o     = 1'b1;
        memwrite_o = 1'b1;
      end
      RTYPEEX: begin
        alusrca_o = 1'b1;
        aluop_o   = ALU_FUNCT;
      end
      RTYPEWB: begin
        regdst_o   = 1'b1;
        regwrite_o = 1'b1;
      end
      BEQEX: begin
        alusrca_o = 1'b1;
        aluop_o   = ALU_SUB;
        pcsrc_o   = PC_ALUOUT;
        branch_o  = 1'b1;
      end
      ADDIWB: regwrite_o = 1'b1;
      JEX: begin
        pcsrc_o   = PC_JUMP;
        pcwrite_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: state sequencing,
// illegal-opcode flag and retired-instruction counter.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             branch,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             mr;
  logic             illegal;

  // Reset masks ready so no load strobes fire in reset.
  assign mr = mem_ready & reset_n;

  // Next state and illegal-opcode detect.
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    unique case (state_q)
      FETCH:   if (mr) state_d = DECODE;
      DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR:
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mr) state_d = MEMWB;
      MEMWR:   if (mr) state_d = FETCH;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // State register and retire counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retires(state_q, mr))
        instret_q <= instret_q + 1'b1;
    end
  end

  assign illegal_op = illegal;
  assign instret    = instret_q;

  mc_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mr),
    .iord_o      (iord),
    .memwrite_o  (memwrite),
    .irwrite_o   (irwrite),
    .pcwrite_o   (pcwrite),
    .branch_o    (branch),
    .pcsrc_o     (pcsrc),
    .alusrca_o   (alusrca),
    .alusrcb_o   (alusrcb),
    .aluop_o     (aluop),
    .regdst_o    (regdst),
    .memtoreg_o  (memtoreg),
    .regwrite_o  (regwrite)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl.
// Checks control vectors cycle by cycle and retire counts.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  op;
  logic        mem_ready;

  logic        iord, memwrite, irwrite, pcwrite, branch;
  logic [1:0]  pcsrc, alusrcb, aluop;
  logic        alusrca, regdst, memtoreg, regwrite, illegal_op;
  logic [31:0] instret;

  logic        d_iord, d_memwrite, d_irwrite, d_pcwrite, d_branch;
  logic [1:0]  d_pcsrc, d_alusrcb, d_aluop;
  logic        d_alusrca, d_regdst, d_memtoreg, d_regwrite, d_illegal;
  logic [3:0]  d_instret;

  logic [15:0] ctl;
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_cnt = 0;

  // {iord,memwrite,irwrite,pcwrite,branch,pcsrc,
  //  alusrca,alusrcb,aluop,regdst,memtoreg,regwrite,illegal}
  localparam logic [15:0] V_FETCH  = 16'h3040;
  localparam logic [15:0] V_FETCH0 = 16'h0040;
  localparam logic [15:0] V_DEC    = 16'h00C0;
  localparam logic [15:0] V_DECILL = 16'h00C1;
  localparam logic [15:0] V_MEMADR = 16'h0180;
  localparam logic [15:0] V_MEMRD  = 16'h8000;
  localparam logic [15:0] V_MEMWB  = 16'h0006;
  localparam logic [15:0] V_MEMWR  = 16'hC000;
  localparam logic [15:0] V_RTEX   = 16'h0120;
  localparam logic [15:0] V_RTWB   = 16'h000A;
  localparam logic [15:0] V_BEQ    = 16'h0B10;
  localparam logic [15:0] V_ADDIEX = 16'h0180;
  localparam logic [15:0] V_ADDIWB = 16'h0002;
  localparam logic [15:0] V_JEX    = 16'h1400;

  assign ctl = {iord, memwrite, irwrite, pcwrite,
                branch, pcsrc, alusrca, alusrcb,
                aluop, regdst, memtoreg, regwrite,
                illegal_op};

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .branch     (branch),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .illegal_op (illegal_op),
    .instret    (instret)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .iord       (d_iord),
    .memwrite   (d_memwrite),
    .irwrite    (d_irwrite),
    .pcwrite    (d_pcwrite),
    .branch     (d_branch),
    .pcsrc      (d_pcsrc),
    .alusrca    (d_alusrca),
    .alusrcb    (d_alusrcb),
    .aluop      (d_aluop),
    .regdst     (d_regdst),
    .memtoreg   (d_memtoreg),
    .regwrite   (d_regwrite),
    .illegal_op (d_illegal),
    .instret    (d_instret)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    mem_ready = 1'b1;
    op = OP_LW;
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== V_FETCH0) begin
      errors++;
      $display("FAIL reset_ctl got=%h exp=%h", ctl, V_FETCH0);
    end
    checks++;
    if (instret !== 32'd0) begin
      errors++;
      $display("FAIL reset_instret got=%0d exp=0", instret);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (ctl !== V_FETCH) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", ctl, V_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [5:0]  o [5] = '{OP_LW, OP_LW, OP_LW, OP_RTYPE, 6'h3F};
    logic [15:0] e [5] = '{V_FETCH, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB};
    for (int i = 0; i < 5; i++) begin
      op = o[i];
      mem_ready = 1'b1;
      #1;
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL lw_c%0d got=%h exp=%h", i, ctl, e[i]);
      end
      checks++;
      if (instret !== exp_cnt) begin
        errors++;
        $display("FAIL lw_cnt%0d got=%0d exp=%0d", i, instret, exp_cnt);
      end
      @(negedge clk);
    end
    exp_cnt++;
    #1;
    checks++;
    if (instret !== exp_cnt) begin
      errors++;
      $display("FAIL lw_retire got=%0d exp=%0d", instret, exp_cnt);
    end
  endtask

  task automatic test_sw();
    logic [5:0]  o [6] = '{OP_SW, OP_SW, OP_SW, 6'h00, 6'h3F, 6'h04};
    logic        m [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] e [6] = '{V_FETCH, V_DEC, V_MEMADR,
                           V_MEMWR, V_MEMWR, V_MEMWR};
    for (int i = 0; i < 6; i++) begin
      op = o[i];
      mem_ready = m[i];
      #1;
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL sw_c%0d got=%h exp=%h", i, ctl, e[i]);
      end
      checks++;
      if (instret !== exp_cnt) begin
        errors++;
        $display("FAIL sw_cnt%0d got=%0d exp=%0d", i, instret, exp_cnt);
      end
      @(negedge clk);
    end
    exp_cnt++;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (instret !== exp_cnt || ctl !== V_FETCH) begin
      errors++;
      $display("FAIL sw_retire got=%0d/%h exp=%0d/%h",
               instret, ctl, exp_cnt, V_FETCH);
    end
  endtask

  task automatic test_mix();
    logic [5:0]  o [14] = '{OP_BEQ, OP_BEQ, OP_BEQ,
                            OP_J, OP_J, 6'h3F,
                            OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
                            OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_LW};
    logic        m [14] = '{1'b1, 1'b0, 1'b0,
                            1'b1, 1'b1, 1'b1,
                            1'b1, 1'b1, 1'b0, 1'b1,
                            1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] e [14] = '{V_FETCH, V_DEC, V_BEQ,
                            V_FETCH, V_DEC, V_JEX,
                            V_FETCH, V_DEC, V_ADDIEX, V_ADDIWB,
                            V_FETCH, V_DEC, V_RTEX, V_RTWB};
    int unsigned c [14] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2,
                            3, 3, 3, 3};
    int unsigned base;
    base = exp_cnt;
    for (int i = 0; i < 14; i++) begin
      op = o[i];
      mem_ready = m[i];
      #1;
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL mix_c%0d got=%h exp=%h", i, ctl, e[i]);
      end
      checks++;
      if (instret !== base + c[i]) begin
        errors++;
        $display("FAIL mix_cnt%0d got=%0d exp=%0d",
                 i, instret, base + c[i]);
      end
      @(negedge clk);
    end
    exp_cnt = base + 4;
    #1;
    checks++;
    if (instret !== exp_cnt) begin
      errors++;
      $display("FAIL mix_total got=%0d exp=%0d", instret, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    logic        m [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] e [3] = '{V_FETCH0, V_FETCH, V_DECILL};
    op = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      mem_ready = m[i];
      #1;
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL ill_c%0d got=%h exp=%h", i, ctl, e[i]);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (ctl !== V_FETCH) begin
      errors++;
      $display("FAIL ill_back got=%h exp=%h", ctl, V_FETCH);
    end
    checks++;
    if (instret !== exp_cnt) begin
      errors++;
      $display("FAIL ill_cnt got=%0d exp=%0d", instret, exp_cnt);
    end
  endtask

  task automatic test_abort();
    logic        m [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] e [4] = '{V_FETCH, V_DEC, V_MEMADR, V_MEMRD};
    op = OP_LW;
    for (int i = 0; i < 4; i++) begin
      mem_ready = m[i];
      #1;
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL abort_c%0d got=%h exp=%h", i, ctl, e[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ctl !== V_FETCH0) begin
      errors++;
      $display("FAIL abort_ctl got=%h exp=%h", ctl, V_FETCH0);
    end
    checks++;
    if (instret !== 32'd0 || d_instret !== 4'd0) begin
      errors++;
      $display("FAIL abort_cnt got=%0d/%0d exp=0/0", instret, d_instret);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== V_FETCH0) begin
      errors++;
      $display("FAIL abort_hold got=%h exp=%h", ctl, V_FETCH0);
    end
    reset_n = 1'b1;
    exp_cnt = 0;
    #1;
    checks++;
    if (ctl !== V_FETCH) begin
      errors++;
      $display("FAIL abort_rel got=%h exp=%h", ctl, V_FETCH);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] e [3] = '{V_FETCH, V_DEC, V_JEX};
    logic [3:0]  w;
    w = 4'd0;
    op = OP_J;
    mem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++;
        if (ctl !== e[i]) begin
          errors++;
          $display("FAIL wrap_j%0d_c%0d got=%h exp=%h", k, i, ctl, e[i]);
        end
        @(negedge clk);
      end
      exp_cnt++;
      w = w + 4'd1;
      #1;
      checks++;
      if (d_instret !== w) begin
        errors++;
        $display("FAIL wrap_cnt%0d got=%0d exp=%0d", k, d_instret, w);
      end
    end
    checks++;
    if (instret !== exp_cnt || d_instret !== 4'd0) begin
      errors++;
      $display("FAIL wrap_final got=%0d/%0d exp=%0d/0",
               instret, d_instret, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_mix();
    test_illegal();
    test_abort();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
